// File: rtl/sta_pipe_adder.sv
// Two-stage pipelined carry-skip adder/subtractor with valid/ready streaming.
// Optional signed-overflow output enabled by defining STA_OVF_EN.
`timescale 1ns/1ps
module sta_pipe_adder #(
    parameter int WIDTH = 16,
    parameter int BLK   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef STA_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NBLK = WIDTH / BLK;

    // Group P/G of one block as a binary tree; node i at level lvl spans bits [i, i+2*lvl).
    function automatic logic [1:0] blk_pg(input logic [BLK-1:0] p, input logic [BLK-1:0] g);
        logic [BLK-1:0] pp;
        logic [BLK-1:0] gg;
        pp = p;
        gg = g;
        for (int lvl = 1; lvl < BLK; lvl = lvl * 2) begin
            for (int i = 0; i + lvl < BLK; i = i + 2 * lvl) begin
                gg[i] = gg[i+lvl] | (pp[i+lvl] & gg[i]);
                pp[i] = pp[i+lvl] & pp[i];
            end
        end
        return {pp[0], gg[0]};
    endfunction

    logic             s1_valid_q;
    logic [WIDTH-1:0] s1_a_q, s1_b_q, s1_p_q, s1_g_q;
    logic             s1_c_q;
    logic [NBLK-1:0]  s1_bp_q, s1_bg_q;

    logic             out_valid_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    logic             s1_adv, s2_adv;
    logic [WIDTH-1:0] b_eff, p_d, g_d;
    logic             c_eff;
    logic [NBLK-1:0]  bp_d, bg_d;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d;
    logic             blk_c, rc, c_msb;

    assign s2_adv   = !out_valid_q | out_ready;
    assign s1_adv   = !s1_valid_q | s2_adv;
    assign in_ready = s1_adv;

    assign b_eff = sub ? ~b : b;
    assign c_eff = sub ? ~cin : cin;
    assign p_d   = a ^ b_eff;
    assign g_d   = a & b_eff;

    always_comb begin
        bp_d = '0;
        bg_d = '0;
        for (int k = 0; k < NBLK; k++) begin
            {bp_d[k], bg_d[k]} = blk_pg(p_d[k*BLK +: BLK], g_d[k*BLK +: BLK]);
        end
    end

    // Block carries skip across the tree P/G; bits inside a block ripple from C_k.
    always_comb begin
        sum_d = '0;
        blk_c = s1_c_q;
        rc    = 1'b0;
        c_msb = 1'b0;
        for (int k = 0; k < NBLK; k++) begin
            rc = blk_c;
            for (int j = 0; j < BLK; j++) begin
                sum_d[k*BLK+j] = s1_a_q[k*BLK+j] ^ s1_b_q[k*BLK+j] ^ rc;
                if (k == NBLK - 1 && j == BLK - 1) c_msb = rc;
                rc = s1_g_q[k*BLK+j] | (s1_p_q[k*BLK+j] & rc);
            end
            blk_c = s1_bg_q[k] | (s1_bp_q[k] & blk_c);
        end
        cout_d = blk_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_p_q     <= '0;
            s1_g_q     <= '0;
            s1_c_q     <= 1'b0;
            s1_bp_q    <= '0;
            s1_bg_q    <= '0;
        end else if (s1_adv) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_a_q  <= a;
                s1_b_q  <= b_eff;
                s1_p_q  <= p_d;
                s1_g_q  <= g_d;
                s1_c_q  <= c_eff;
                s1_bp_q <= bp_d;
                s1_bg_q <= bg_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
        end else if (s2_adv) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                sum_q  <= sum_d;
                cout_q <= cout_d;
            end
        end
    end

`ifdef STA_OVF_EN
    logic ovf_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (s2_adv && s1_valid_q) begin
            ovf_q <= c_msb ^ cout_d;
        end
    end
    assign ovf = ovf_q;
`else
    logic unused_c_msb;
    assign unused_c_msb = c_msb ^ rc;
`endif

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_sta_pipe_adder.sv
// Directed self-checking bench for sta_pipe_adder (WIDTH=16, BLK=4).
`timescale 1ns/1ps
module tb_sta_pipe_adder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        cin = 1'b0;
    logic        sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] sum;
    logic        cout;
`ifdef STA_OVF_EN
    logic        ovf;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    sta_pipe_adder #(.WIDTH(16), .BLK(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef STA_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        n_checks++;
        if (sum !== 16'h0000) begin n_fail++; $display("FAIL reset_sum got=%h want=0000", sum); end
        n_checks++;
        if (cout !== 1'b0) begin n_fail++; $display("FAIL reset_cout got=%b want=0", cout); end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_out_valid got=%b want=0", out_valid); end
    endtask

    task automatic test_latency();
        a = 16'h00FF; b = 16'h0001; cin = 1'b0; sub = 1'b0;
        in_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL lat_in_ready got=%b want=1", in_ready); end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_early_valid got=%b want=0", out_valid); end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL lat_valid_2clk got=%b want=1", out_valid); end
        n_checks++;
        if (sum !== 16'h0100) begin n_fail++; $display("FAIL lat_sum got=%h want=0100", sum); end
        n_checks++;
        if (cout !== 1'b0) begin n_fail++; $display("FAIL lat_cout got=%b want=0", cout); end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_drain got=%b want=0", out_valid); end
    endtask

    task automatic test_vectors();
        vec_t v [9];
        v[0] = '{16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0};
        v[1] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        v[2] = '{16'h0009, 16'h0004, 1'b1, 1'b1, 16'h0004, 1'b1, 1'b0};
        v[3] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
        v[4] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        v[5] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        v[6] = '{16'hABCD, 16'h1111, 1'b1, 1'b0, 16'hBCDF, 1'b0, 1'b0};
        v[7] = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        v[8] = '{16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            a = v[i].a; b = v[i].b; cin = v[i].cin; sub = v[i].sub;
            in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            for (int t = 0; t < 6 && out_valid !== 1'b1; t++) @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1) begin n_fail++; $display("FAIL vec%0d_timeout got=%b want=1", i, out_valid); end
            n_checks++;
            if (sum !== v[i].s) begin n_fail++; $display("FAIL vec%0d_sum got=%h want=%h", i, sum, v[i].s); end
            n_checks++;
            if (cout !== v[i].co) begin n_fail++; $display("FAIL vec%0d_cout got=%b want=%b", i, cout, v[i].co); end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] ba [4];
        logic [15:0] bb [4];
        logic        bs [4];
        logic [15:0] es [4];
        logic        ec [4];
        int idx, nout, first_cyc, last_cyc;
        logic fire;
        ba = '{16'h0001, 16'h0010, 16'hF000, 16'h0100};
        bb = '{16'h0001, 16'h0020, 16'h1000, 16'h0001};
        bs = '{1'b0, 1'b0, 1'b0, 1'b1};
        es = '{16'h0002, 16'h0030, 16'h0000, 16'h00FF};
        ec = '{1'b0, 1'b0, 1'b1, 1'b1};
        idx = 0; nout = 0; first_cyc = -1; last_cyc = -1;
        @(negedge clk);
        out_ready = 1'b0;
        cin = 1'b0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            in_valid = (idx < 4);
            if (idx < 4) begin a = ba[idx]; b = bb[idx]; sub = bs[idx]; end
            #1;
            if (out_valid === 1'b1) begin
                n_checks++;
                if (sum !== es[0]) begin n_fail++; $display("FAIL stall_hold_sum cyc%0d got=%h want=%h", cyc, sum, es[0]); end
            end
            fire = in_valid && in_ready;
            @(posedge clk);
            if (fire) idx++;
            @(negedge clk);
        end
        in_valid = (idx < 4);
        if (idx < 4) begin a = ba[idx]; b = bb[idx]; sub = bs[idx]; end
        #1;
        n_checks++;
        if (idx !== 2) begin n_fail++; $display("FAIL stall_accepts got=%0d want=2", idx); end
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready got=%b want=0", in_ready); end
        n_checks++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_out_valid got=%b want=1", out_valid); end
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 12 && nout < 4; cyc++) begin
            in_valid = (idx < 4);
            if (idx < 4) begin a = ba[idx]; b = bb[idx]; sub = bs[idx]; end
            #1;
            fire = in_valid && in_ready;
            if (out_valid === 1'b1) begin
                n_checks++;
                if (sum !== es[nout]) begin n_fail++; $display("FAIL stream_sum%0d got=%h want=%h", nout, sum, es[nout]); end
                n_checks++;
                if (cout !== ec[nout]) begin n_fail++; $display("FAIL stream_cout%0d got=%b want=%b", nout, cout, ec[nout]); end
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                nout++;
            end
            @(posedge clk);
            if (fire) idx++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        n_checks++;
        if (nout !== 4) begin n_fail++; $display("FAIL stream_count got=%0d want=4", nout); end
        n_checks++;
        if (last_cyc - first_cyc !== 3) begin n_fail++; $display("FAIL stream_rate got=%0d want=3", last_cyc - first_cyc); end
    endtask

    task automatic test_reset_midflight();
        @(negedge clk);
        out_ready = 1'b0;
        a = 16'h0003; b = 16'h0004; cin = 1'b0; sub = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        a = 16'h0005;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL mid_full got=%b%b want=01", in_ready, out_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_async_valid got=%b want=0", out_valid); end
        n_checks++;
        if (sum !== 16'h0000) begin n_fail++; $display("FAIL mid_async_sum got=%h want=0000", sum); end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale t%0d got=%b want=0", t, out_valid); end
        end
        a = 16'h0020; b = 16'h0002;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int t = 0; t < 6 && out_valid !== 1'b1; t++) @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || sum !== 16'h0022) begin
            n_fail++; $display("FAIL mid_new_beat got=%b/%h want=1/0022", out_valid, sum);
        end
        @(negedge clk);
    endtask

`ifdef STA_OVF_EN
    task automatic test_ovf();
        vec_t v [3];
        v[0] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        v[1] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        v[2] = '{16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a = v[i].a; b = v[i].b; cin = v[i].cin; sub = v[i].sub;
            in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            for (int t = 0; t < 6 && out_valid !== 1'b1; t++) @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 || sum !== v[i].s) begin
                n_fail++; $display("FAIL ovf%0d_sum got=%b/%h want=1/%h", i, out_valid, sum, v[i].s);
            end
            n_checks++;
            if (ovf !== v[i].ov) begin n_fail++; $display("FAIL ovf%0d_flag got=%b want=%b", i, ovf, v[i].ov); end
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_latency();
        test_vectors();
        test_back_to_back();
        test_reset_midflight();
`ifdef STA_OVF_EN
        test_ovf();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
